// File: rtl/countdown_timer.sv
// Seconds countdown timer: CLK_HZ prescaler, load/start/pause/ack strobes, done pulse and alarm level.
// Build option COUNTDOWN_AUTO_RELOAD_EN: expiry reloads from the last loaded value and keeps running.
//
// state     | meaning
// S_IDLE    | stopped (after reset, load or ack), waiting for start
// S_RUN     | prescaler advancing, remaining counts down once per second
// S_PAUSED  | frozen mid-second, prescaler value held for resume
// S_EXPIRED | reached zero, alarm high until ack or load

module countdown_timer #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned WIDTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             alarm_ack_i,
  output logic [WIDTH-1:0] remaining_o,
  output logic             running_o,
  output logic             done_o,
  output logic             alarm_o
);

  localparam int unsigned    PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             alarm_q, alarm_d;
  logic             running_q;
  logic             tick;
  logic             reload_hit;

  assign tick       = (state_q == S_RUN) && (presc_q == PRESC_MAX);
  assign reload_hit = AUTO_RELOAD && (reload_q != '0);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    alarm_d  = alarm_q;

    if (load_i) begin
      rem_d    = load_value_i;
      reload_d = load_value_i;
      presc_d  = '0;
      alarm_d  = 1'b0;
      state_d  = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_PAUSED: begin
          if (start_i && (rem_q != '0)) state_d = S_RUN;
        end
        S_RUN: begin
          if (tick) begin
            presc_d = '0;
            if (rem_q > WIDTH'(1)) begin
              rem_d = rem_q - WIDTH'(1);
            end else if (reload_hit) begin
              rem_d  = reload_q;
              done_d = 1'b1;
            end else begin
              rem_d   = '0;
              done_d  = 1'b1;
              alarm_d = 1'b1;
              state_d = S_EXPIRED;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // start outranks pause; expiry outranks both
          if (pause_i && !start_i && (state_d == S_RUN)) state_d = S_PAUSED;
        end
        S_EXPIRED: begin
          if (alarm_ack_i) begin
            alarm_d = 1'b0;
            rem_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      reload_q  <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      running_q <= (state_d == S_RUN);
    end
  end

  assign remaining_o = rem_q;
  assign running_o   = running_q;
  assign done_o      = done_q;
  assign alarm_o     = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random strobes, per-cycle scoreboard fed by a
// behavioural model; honours COUNTDOWN_AUTO_RELOAD_EN when the design is built with it.

module tb_countdown_timer;

  localparam int CLK_HZ = 10;
  localparam int WIDTH  = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

  logic             clk_i;
  logic             rst_n_i;
  logic             load_i;
  logic [WIDTH-1:0] load_value_i;
  logic             start_i;
  logic             pause_i;
  logic             alarm_ack_i;
  logic [WIDTH-1:0] remaining_o;
  logic             running_o;
  logic             done_o;
  logic             alarm_o;

  countdown_timer #(.CLK_HZ(CLK_HZ), .WIDTH(WIDTH)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_i       (load_i),
    .load_value_i (load_value_i),
    .start_i      (start_i),
    .pause_i      (pause_i),
    .alarm_ack_i  (alarm_ack_i),
    .remaining_o  (remaining_o),
    .running_o    (running_o),
    .done_o       (done_o),
    .alarm_o      (alarm_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    int rem;
    int run;
    int done;
    int alarm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model: mode, seconds left, last loaded value, cycles elapsed in the current second
  int m_mode, m_rem, m_reload, m_phase, m_done, m_alarm;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_reload = 0; m_phase = 0; m_done = 0; m_alarm = 0;
  endtask

  task automatic model_step(bit ld, int lv, bit st, bit pa, bit ack);
    m_done = 0;
    if (ld) begin
      m_rem = lv; m_reload = lv; m_phase = 0; m_alarm = 0; m_mode = M_IDLE;
    end else if (m_mode == M_IDLE || m_mode == M_PAUSED) begin
      if (st && m_rem > 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == CLK_HZ) begin
        m_phase = 0;
        if (m_rem > 1) m_rem--;
        else begin
          m_done = 1;
          if (AUTO && m_reload > 0) m_rem = m_reload;
          else begin
            m_rem = 0; m_alarm = 1; m_mode = M_EXPIRED;
          end
        end
      end
      if (m_mode == M_RUN && pa && !st) m_mode = M_PAUSED;
    end else if (ack) begin
      m_alarm = 0; m_rem = 0; m_mode = M_IDLE;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.rem = m_rem; e.run = (m_mode == M_RUN) ? 1 : 0; e.done = m_done; e.alarm = m_alarm;
    exp_q.push_back(e);
  endtask

  task automatic cycle(bit ld, int lv, bit st, bit pa, bit ack);
    @(negedge clk_i);
    load_i = ld; load_value_i = lv[WIDTH-1:0]; start_i = st; pause_i = pa; alarm_ack_i = ack;
    model_step(ld, lv, st, pa, ack);
    push_exp();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    load_i = 1'b0; load_value_i = '0; start_i = 1'b0; pause_i = 1'b0; alarm_ack_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    check("rst_async_remaining", remaining_o, 0);
    check("rst_async_running", running_o, 0);
    check("rst_async_done", done_o, 0);
    check("rst_async_alarm", alarm_o, 0);
    model_reset();
    push_exp();
    @(negedge clk_i);
    push_exp();
    #2 rst_n_i = 1'b1;
  endtask

  // scoreboard monitor: one expected snapshot per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_remaining", remaining_o, e.rem);
        check("sb_running", running_o, e.run);
        check("sb_done", done_o, e.done);
        check("sb_alarm", alarm_o, e.alarm);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r, lv, sel;
    bit  ld, st, pa, ack;
    rst_n_i = 1'b0;
    load_i = 1'b0; load_value_i = '0; start_i = 1'b0; pause_i = 1'b0; alarm_ack_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_remaining", remaining_o, 0);
    check("reset_running", running_o, 0);
    check("reset_done", done_o, 0);
    check("reset_alarm", alarm_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // load 3, start: 2 at cycle 10, 1 at 20, 0 with done at 30, alarm held
    cycle(1'b1, 3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(9);  settle(); check("c030_rem_c9", remaining_o, 3);
    idle(1);  settle(); check("c030_rem_c10", remaining_o, 2);
    idle(10); settle(); check("c030_rem_c20", remaining_o, 1);
    idle(9);  settle(); check("c030_done_c29", done_o, 0);
    idle(1);  settle(); check("c030_rem_c30", remaining_o, 0);
    check("c030_done_c30", done_o, 1);
    check("c030_alarm_c30", alarm_o, 1);
    check("c030_running_c30", running_o, 0);
    idle(1);  settle(); check("c030_done_c31", done_o, 0);
    check("c030_alarm_c31", alarm_o, 1);
    // ack with start in the same cycle: alarm clears, start ignored
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    settle(); check("c034_alarm", alarm_o, 0);
    check("c034_running", running_o, 0);
    idle(2); settle(); check("c034_stays_idle", running_o, 0);
`endif

    // pause at cycle 14, resume 7 cycles later, next decrement 6 cycles after resume
    cycle(1'b1, 5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(13);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0);
    settle(); check("c031_paused_running", running_o, 0);
    check("c031_paused_rem", remaining_o, 4);
    idle(6);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    settle(); check("c031_resumed_running", running_o, 1);
    idle(5); settle(); check("c031_rem_resume_plus5", remaining_o, 4);
    idle(1); settle(); check("c031_rem_resume_plus6", remaining_o, 3);

    // load + start + pause together: load wins
    cycle(1'b1, 7, 1'b1, 1'b1, 1'b0);
    settle(); check("c032_rem", remaining_o, 7);
    check("c032_running", running_o, 0);
    idle(3); settle(); check("c032_stays_idle", running_o, 0);

    // reset mid-countdown at remaining 4; later start ignored until nonzero load
    cycle(1'b1, 6, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle(20); settle(); check("c033_rem_before_reset", remaining_o, 4);
    do_reset();
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    settle(); check("c033_start_ignored", running_o, 0);
    cycle(1'b1, 2, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b0);
    settle(); check("c033_start_after_load", running_o, 1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // running from load 2: done at 20 and 40, reload to 2, alarm low
    idle(19); settle(); check("c035_done_c19", done_o, 0);
    idle(1);  settle(); check("c035_done_c20", done_o, 1);
    check("c035_rem_c20", remaining_o, 2);
    check("c035_alarm_c20", alarm_o, 0);
    check("c035_running_c20", running_o, 1);
    idle(10); settle(); check("c035_rem_c30", remaining_o, 1);
    idle(10); settle(); check("c035_done_c40", done_o, 1);
    check("c035_alarm_c40", alarm_o, 0);
`endif

    cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        do_reset();
      end else begin
        ld  = ($urandom_range(0, 59) == 0);
        lv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        sel = $urandom_range(0, 15);
        st  = (sel < 2);
        pa  = (sel == 2);
        ack = (sel == 3) || (sel == 4);
        cycle(ld, lv, st, pa, ack);
      end
    end

    idle(2);
    settle();
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, giving input clock cycles per second.
REQ-002 The block SHALL have parameter WIDTH, default 4, giving the bit width of the seconds value (max 2^WIDTH-1).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  single-cycle strobe; captures load_value.
REQ-006 load_value  input  WIDTH  seconds to count down from.
REQ-007 start  input  1  single-cycle strobe; begins or resumes the countdown.
REQ-008 pause  input  1  single-cycle strobe; freezes the countdown.
REQ-009 alarm_ack  input  1  single-cycle strobe; clears the alarm.
REQ-010 remaining  output  WIDTH  registered seconds left.
REQ-011 running  output  1  high while in RUN.
REQ-012 done  output  1  one-cycle pulse on expiry.
REQ-013 alarm  output  1  level; high from expiry until acknowledged or reloaded.

Function
REQ-014 The block SHALL implement states IDLE, RUN, PAUSED and EXPIRED, with the state in a registered encoding.
REQ-015 A prescaler SHALL count clk cycles from 0 to CLK_HZ-1, wrap to 0, and produce one tick per CLK_HZ cycles, advancing only in RUN.
REQ-016 Input priority in the same cycle SHALL be load > alarm_ack > start > pause.
REQ-017 The load input in any state SHALL set remaining and reload_reg to load_value, clear the prescaler, clear alarm, and enter IDLE on the next edge.
REQ-018 IDLE or PAUSED with start and remaining != 0 SHALL enter RUN; start with remaining == 0 SHALL be ignored.
REQ-019 RUN with pause SHALL enter PAUSED and hold the prescaler value, so that resume continues the partial second.
REQ-020 The first decrement SHALL occur exactly CLK_HZ cycles after the edge on which start is accepted.
REQ-021 On a tick in RUN with remaining > 1, the block SHALL decrement remaining by 1.
REQ-022 On a tick in RUN with remaining == 1, the block SHALL set remaining to 0, pulse done high for one cycle, set alarm, and enter EXPIRED.
REQ-023 EXPIRED with alarm_ack SHALL clear alarm and enter IDLE with remaining = 0; start and pause SHALL be ignored in EXPIRED.
REQ-024 pause outside RUN, and alarm_ack outside EXPIRED, SHALL have no effect.
REQ-025 remaining SHALL never wrap below 0; the decrement SHALL be WIDTH-bit unsigned arithmetic.
REQ-026 running SHALL equal (state == RUN), registered, with no combinational path from any input.

Reset
REQ-027 Assertion of rst_n low SHALL immediately force IDLE, remaining = 0, reload_reg = 0, prescaler = 0, running = 0, done = 0 and alarm = 0, regardless of clk.
REQ-028 Reset SHALL take effect mid-countdown without completing the current second, and deassertion SHALL be followed by normal operation on the next rising edge.

Configuration
REQ-029 Macro COUNTDOWN_AUTO_RELOAD_EN SHALL select the expiry behaviour.
  - Defined: on the expiry tick, pulse done, reload remaining from reload_reg, stay in RUN, and leave alarm low.
  - Defined, reload_reg == 0: follow the undefined behaviour.
  - Undefined: behave as in REQ-022.

Verification (CLK_HZ = 10 for simulation)
REQ-030 load 3, then start -> remaining reads 2 at cycle 10, 1 at cycle 20 and 0 at cycle 30; done is high for exactly one cycle at cycle 30; alarm is held high.
REQ-031 load 5, start, pause at cycle 14, start again 7 cycles later -> next decrement (4 to 3) occurs 6 cycles after resume.
REQ-032 load, start and pause all asserted in the same cycle with load_value 7 -> IDLE, remaining 7, running 0.
REQ-033 rst_n pulsed low during RUN at remaining 4 -> all outputs 0 asynchronously; a later start is ignored until a nonzero load.
REQ-034 Alarm high in EXPIRED, then alarm_ack -> alarm 0 on the next edge; start in the same cycle as alarm_ack -> ignored, state IDLE.
REQ-035 With COUNTDOWN_AUTO_RELOAD_EN, load 2 and start -> done pulses at cycles 20, 40 and 60; remaining sequence is 2,1,2,1,...; alarm stays 0.
